dpram_porta_arb: RTL
====================

Name: dpram_porta_arb

Overview:
- Round-robin arbiter sharing the read/write port A of a dual-port block RAM between two requesters (e.g. host register bus and a DSP/config sequencer).
- Port B stays private to its reader.
- Each requester gets a valid/ready request handshake and a read-response strobe aligned to the RAM's one-cycle registered-address read latency.
- A burst counter bounds how long one requester may hold the port while the other waits.

Parameters:
- aw, 8, RAM address width.
- dw, 8, RAM data width.
- maxburst, 4, maximum consecutive accepts by the current owner while the other requester is waiting; legal range 1..255.

Ports:
- clk  in  1  single clock, also drives RAM port A.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_we  in  1  1=write, 0=read.
- req0_addr  in  aw  address.
- req0_wdata  in  dw  write data.
- rsp0_valid  out  1  read data for requester 0 valid on rsp_data.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid: same as requester 0, for requester 1.
- rsp_data  out  dw  shared read-data bus, equal to ram_dout.
- ram_addr  out  aw  to RAM addra.
- ram_din  out  dw  to RAM dina.
- ram_wen  out  1  to RAM wena.
- ram_dout  in  dw  from RAM douta.

Behaviour:
- Registered state:
  - owner (1 bit; reset value 1, so requester 0 wins the first tie).
  - burst count cnt (8 bits; reset 0).
  - rsp0_valid, rsp1_valid (reset 0).
- Grant selection is combinational each cycle, from owner, cnt and both valids:
  - If req[owner]_valid and not (cnt>=maxburst and req[other]_valid): grant owner.
  - Else if req[other]_valid: grant other.
  - Else: no grant.
- Accept rules:
  - req_ready is 1 only for the granted requester. At most one ready is high per cycle. Ready never asserts without the matching valid.
  - Accept = valid & ready.
  - A request stays presented (valid, addr, we, wdata stable) until accepted. The arbiter must not depend on this, and samples only at accept.
- RAM drive:
  - ram_addr and ram_din mux the granted requester's fields combinationally. With no grant they hold requester 0's fields.
  - ram_wen = accept & granted we.
  - Zero-cycle issue: the RAM registers the address at the accepting edge.
- Counter and owner update at each clock edge with an accept:
  - If grant == owner: cnt <= saturating cnt+1.
  - Else: owner <= grant, cnt <= 1.
  - No accept: owner and cnt hold.
- Read response:
  - rspN_valid <= accept_N & ~weN, so rspN_valid is high exactly the cycle after the accepting edge.
  - rsp_data = ram_dout in that cycle.
  - Writes produce no response.
  - Back-to-back reads give back-to-back responses at throughput 1 per cycle.
- Read-after-write:
  - A read accepted the cycle after a write to the same address returns the new data, since the RAM write and the address register update on the same edge.
  - A same-cycle collision is impossible, because only one grant exists per cycle.
- Requester switch costs no bubble. maxburst=1 gives strict alternation when both are continuously valid.
- Reset mid-operation (async assert):
  - ready, ram_wen and rsp valids drop to 0 immediately.
  - An outstanding read response is lost, and the requester must reissue.
  - State returns to the reset values.
- The RAM contents are not touched by reset.

Test Plan:
- Reset release, both idle → all readys, ram_wen, rsp valids 0. Requester 0 writes 0x5A to addr 0x10 → req0_ready=1 same cycle, ram_wen=1, ram_addr=0x10.
- Requester 1 reads addr 0x10 the next cycle → rsp1_valid=1 one cycle after accept, rsp_data=0x5A, rsp0_valid=0.
- Both valid from reset, maxburst=4, continuous reads → grant pattern 0,0,0,0,1,1,1,1,0… with no idle cycles. Each rspN_valid follows its accept by exactly 1 cycle.
- Only requester 1 valid for 10 cycles with maxburst=4 → all 10 accepted consecutively (no forced switch without contention). Requester 0 then raises valid → accepted at the next grant point.
- Write addr 0x20=0x11, then read 0x20 the very next cycle (same requester) → rsp_data=0x11.
- Assert rst_n low in the cycle after a read accept → rsp valid stays 0 and no response issues after release. A fresh read afterwards returns the stored data.

Source files
------------

// File: rtl/dpram_porta_arb.sv
// Round-robin arbiter sharing RAM port A between two valid/ready requesters,
// with a burst limit under contention and one-cycle read-response strobes.
module dpram_porta_arb #(
    parameter int unsigned aw       = 8,
    parameter int unsigned dw       = 8,
    parameter int unsigned maxburst = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [aw-1:0] req0_addr,
    input  logic [dw-1:0] req0_wdata,
    output logic          rsp0_valid,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [aw-1:0] req1_addr,
    input  logic [dw-1:0] req1_wdata,
    output logic          rsp1_valid,

    output logic [dw-1:0] rsp_data,

    output logic [aw-1:0] ram_addr,
    output logic [dw-1:0] ram_din,
    output logic          ram_wen,
    input  logic [dw-1:0] ram_dout
);

    localparam int unsigned cw = 8;
    localparam logic [cw-1:0] cnt_max   = '1;
    localparam logic [cw-1:0] burst_lim = cw'(maxburst);

    if (maxburst < 1 || maxburst > 255) begin : g_bad_maxburst
        $error("dpram_porta_arb: maxburst must be in 1..255");
    end

    logic          owner_q;
    logic          owner_d;
    logic [cw-1:0] cnt_q;
    logic [cw-1:0] cnt_d;
    logic          rsp0_d;
    logic          rsp1_d;

    logic          owner_valid;
    logic          other_valid;
    logic          yield;
    logic          grant_valid;
    logic          grant_id;
    logic          grant_we;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= 1'b1;
            cnt_q      <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rsp0_valid <= rsp0_d;
            rsp1_valid <= rsp1_d;
        end
    end

    // Grant selection; cnt==0 only before the first accept, so the
    // reset owner yields the first tie and requester 0 goes first.
    always_comb begin
        owner_valid = 1'b0;
        other_valid = 1'b0;
        yield       = 1'b0;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        grant_we    = 1'b0;

        owner_valid = owner_q ? req1_valid : req0_valid;
        other_valid = owner_q ? req0_valid : req1_valid;
        yield       = other_valid && ((cnt_q >= burst_lim) || (cnt_q == '0));

        if (rst_n) begin
            if (owner_valid && !yield) begin
                grant_valid = 1'b1;
                grant_id    = owner_q;
            end else if (other_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~owner_q;
            end
        end

        grant_we = grant_id ? req1_we : req0_we;
    end

    // Next-state: burst counter, ownership and response strobes
    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rsp0_d  = 1'b0;
        rsp1_d  = 1'b0;

        if (grant_valid) begin
            if (grant_id == owner_q) begin
                if (cnt_q != cnt_max) begin
                    cnt_d = cnt_q + cw'(1);
                end
            end else begin
                owner_d = grant_id;
                cnt_d   = cw'(1);
            end
            rsp0_d = !grant_id && !grant_we;
            rsp1_d =  grant_id && !grant_we;
        end
    end

    // Outputs: handshakes and port-A drive, requester 0 fields when idle
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        ram_addr   = req0_addr;
        ram_din    = req0_wdata;
        ram_wen    = 1'b0;

        if (grant_valid) begin
            req0_ready = !grant_id;
            req1_ready =  grant_id;
            ram_wen    = grant_we;
            if (grant_id) begin
                ram_addr = req1_addr;
                ram_din  = req1_wdata;
            end
        end
    end

    assign rsp_data = ram_dout;

endmodule
